// File: rtl/reg_dump_unit.sv
// Register-file dump engine: walks every register through a combinational read
// port and streams each word, MSB byte first, over a valid/ready TX handshake.
module reg_dump_unit #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 5,
    parameter int NB_BYTE = 8
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic               i_start,
    output logic [NB_ADDR-1:0] o_rd_addr,
    input  logic [NB_DATA-1:0] i_rd_data,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic               o_busy,
    output logic               o_done
);

    localparam int NB_WORD_BYTES = NB_DATA / 8;
    localparam int NB_BIDX       = (NB_WORD_BYTES > 1) ? $clog2(NB_WORD_BYTES) : 1;

    localparam logic [NB_BIDX-1:0] LAST_BYTE = NB_BIDX'(NB_WORD_BYTES - 1);
    localparam logic [NB_ADDR-1:0] LAST_REG  = {NB_ADDR{1'b1}};

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]         r_state;
    logic [NB_ADDR-1:0] r_reg_idx;
    logic [NB_BIDX-1:0] r_byte_idx;
    logic [NB_DATA-1:0] r_word;

    logic               w_transfer;
    logic               w_last_byte;
    logic [NB_BYTE-1:0] w_byte;

    assign w_transfer  = (r_state == ST_SEND) && i_tx_ready;
    assign w_last_byte = (r_byte_idx == LAST_BYTE);

    // Byte 0 is the most significant byte of the snapshot.
    always_comb begin
        w_byte = '0;
        for (int b = 0; b < NB_WORD_BYTES; b++) begin
            if (r_byte_idx == NB_BIDX'(b)) begin
                w_byte = r_word[NB_DATA-1-NB_BYTE*b -: NB_BYTE];
            end
        end
    end

    assign o_rd_addr  = r_reg_idx;
    assign o_tx_valid = (r_state == ST_SEND);
    assign o_tx_data  = (r_state == ST_SEND) ? w_byte : '0;
    assign o_busy     = (r_state != ST_IDLE);
    assign o_done     = (r_state == ST_DONE);

    // The last-register test is an equality compare so the index never wraps.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= ST_IDLE;
            r_reg_idx  <= '0;
            r_byte_idx <= '0;
            r_word     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_reg_idx  <= '0;
                    r_byte_idx <= '0;
                    if (i_start) begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_word     <= i_rd_data;
                    r_byte_idx <= '0;
                    r_state    <= ST_SEND;
                end
                ST_SEND: begin
                    if (w_transfer) begin
                        if (!w_last_byte) begin
                            r_byte_idx <= r_byte_idx + NB_BIDX'(1);
                        end else if (r_reg_idx == LAST_REG) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_reg_idx <= r_reg_idx + NB_ADDR'(1);
                            r_state   <= ST_LOAD;
                        end
                    end
                end
                default: begin
                    r_reg_idx <= '0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_unit.sv
// Self-checking bench for reg_dump_unit: expected byte streams come from a
// register-array model; dumps run with steady, patterned and random TX ready.
module tb_reg_dump_unit;

    localparam int HOOK_NONE  = 0;
    localparam int HOOK_START = 1;
    localparam int HOOK_SNAP  = 2;
    localparam int HOOK_RESET = 3;
    localparam int HOOK_HELD  = 4;

    logic        clk;
    logic        resetN;
    logic        start;
    logic [4:0]  rdAddr;
    logic [31:0] rdData;
    logic [7:0]  txData;
    logic        txValid;
    logic        txReady;
    logic        busy;
    logic        done;

    logic [31:0] regs [32];
    logic [7:0]  gotBytes [$];
    logic [7:0]  expBytes [$];

    int assertCount = 0;
    int failCount   = 0;
    int doneAt;
    int busyCycles;

    reg_dump_unit #(.NB_DATA(32), .NB_ADDR(5), .NB_BYTE(8)) dut (
        .clk        (clk),
        .i_reset    (resetN),
        .i_start    (start),
        .o_rd_addr  (rdAddr),
        .i_rd_data  (rdData),
        .o_tx_data  (txData),
        .o_tx_valid (txValid),
        .i_tx_ready (txReady),
        .o_busy     (busy),
        .o_done     (done)
    );

    assign rdData = regs[rdAddr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic startVal, input logic readyVal);
        start   = startVal;
        txReady = readyVal;
    endtask

    // Whole dump as the model sees it: every register, MSB byte first.
    task automatic buildExpected();
        expBytes.delete();
        for (int r = 0; r < 32; r++) begin
            for (int b = 0; b < 4; b++) begin
                expBytes.push_back(8'(regs[r] >> (24 - 8 * b)));
            end
        end
    endtask

    task automatic compareStream(input string tag, input int expectLen);
        int n;
        checkOutput({tag, "_len"}, gotBytes.size(), expectLen);
        n = (gotBytes.size() < expectLen) ? gotBytes.size() : expectLen;
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s[%0d]", tag, i), gotBytes[i], expBytes[i]);
        end
    endtask

    task automatic idleCheck(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            applyStimulus(1'b0, 1'b0);
            #1;
            checkOutput("idleBusy", busy, 0);
            checkOutput("idleDone", done, 0);
        end
    endtask

    // Call j samples cycle N+j, where edge N is the edge that sees the start pulse.
    task automatic runDump(input int readyMode, input int hook, input int budget,
                           output int doneIdx, output int busyCnt);
        bit         stallPrev;
        bit         pulsed;
        bit         written;
        logic [7:0] dataPrev;
        logic [4:0] addrPrev;
        logic       s;
        logic       rdy;
        doneIdx   = -1;
        busyCnt   = 0;
        stallPrev = 0;
        pulsed    = 0;
        written   = 0;
        dataPrev  = '0;
        addrPrev  = '0;
        gotBytes.delete();
        for (int j = 0; j < budget && doneIdx < 0; j++) begin
            @(negedge clk);
            s = (j == 0) || (hook == HOOK_HELD);
            if (hook == HOOK_START && !pulsed && txValid && rdAddr == 5'd3) begin
                s      = 1'b1;
                pulsed = 1;
            end
            if (hook == HOOK_SNAP && !written && gotBytes.size() == 21) begin
                regs[5] = 32'hDEADBEEF;
                written = 1;
            end
            if (hook == HOOK_RESET && txValid && rdAddr == 5'd10 && gotBytes.size() == 42) begin
                resetN = 1'b0;
                #1;
                checkOutput("rstValid", txValid, 0);
                checkOutput("rstBusy", busy, 0);
                checkOutput("rstAddr", rdAddr, 0);
                checkOutput("rstData", txData, 0);
                checkOutput("rstDone", done, 0);
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    #1;
                    checkOutput("rstNoDone", done, 0);
                end
                resetN = 1'b1;
                break;
            end
            case (readyMode)
                0:       rdy = 1'b1;
                1:       rdy = (j % 4 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            applyStimulus(s, rdy);
            #1;
            if (stallPrev) begin
                checkOutput("holdValid", txValid, 1);
                checkOutput("holdData", txData, dataPrev);
                checkOutput("holdAddr", rdAddr, addrPrev);
            end
            stallPrev = txValid && !txReady;
            dataPrev  = txData;
            addrPrev  = rdAddr;
            if (busy) busyCnt++;
            if (txValid && txReady) gotBytes.push_back(txData);
            if (done) doneIdx = j;
        end
        start = 1'b0;
    endtask

    initial begin
        resetN  = 1'b0;
        start   = 1'b0;
        txReady = 1'b0;
        for (int k = 0; k < 32; k++) regs[k] = 32'hA0B0C000 + k;

        // Reset and idle
        repeat (3) @(negedge clk);
        #1;
        checkOutput("resetAddr", rdAddr, 0);
        checkOutput("resetData", txData, 0);
        checkOutput("resetValid", txValid, 0);
        checkOutput("resetBusy", busy, 0);
        checkOutput("resetDone", done, 0);
        resetN = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            applyStimulus(1'b0, 1'b1);
            #1;
            checkOutput("idleBusy", busy, 0);
            checkOutput("idleValid", txValid, 0);
        end

        // Full dump, ready held high
        buildExpected();
        runDump(0, HOOK_NONE, 400, doneAt, busyCycles);
        checkOutput("fullDoneAt", doneAt, 161);
        checkOutput("fullBusyCycles", busyCycles, 161);
        compareStream("full", 128);
        idleCheck(3);
        checkOutput("fullAddrBack", rdAddr, 0);

        // Backpressure: one ready cycle in four
        runDump(1, HOOK_NONE, 2000, doneAt, busyCycles);
        checkOutput("bpDoneSeen", doneAt > 0, 1);
        compareStream("bp", 128);
        idleCheck(2);

        // Snapshot: register 5 rewritten after its first byte goes out
        buildExpected();
        runDump(0, HOOK_SNAP, 400, doneAt, busyCycles);
        checkOutput("snapDoneAt", doneAt, 161);
        compareStream("snapOld", 128);
        buildExpected();
        runDump(0, HOOK_NONE, 400, doneAt, busyCycles);
        compareStream("snapNew", 128);
        checkOutput("snapNewB0", gotBytes.size() > 23 ? gotBytes[20] : 8'h00, 8'hDE);
        checkOutput("snapNewB1", gotBytes.size() > 23 ? gotBytes[21] : 8'h00, 8'hAD);
        checkOutput("snapNewB2", gotBytes.size() > 23 ? gotBytes[22] : 8'h00, 8'hBE);
        checkOutput("snapNewB3", gotBytes.size() > 23 ? gotBytes[23] : 8'h00, 8'hEF);

        // Start pulse while busy is ignored
        buildExpected();
        runDump(0, HOOK_START, 400, doneAt, busyCycles);
        checkOutput("ignDoneAt", doneAt, 161);
        checkOutput("ignBusyCycles", busyCycles, 161);
        compareStream("ign", 128);
        idleCheck(8);

        // Reset in the middle of register 10
        buildExpected();
        runDump(0, HOOK_RESET, 400, doneAt, busyCycles);
        checkOutput("rstNoDoneSeen", doneAt, -1);
        compareStream("rstPartial", 42);
        idleCheck(2);
        runDump(0, HOOK_NONE, 400, doneAt, busyCycles);
        checkOutput("rstRestartDone", doneAt, 161);
        compareStream("rstRestart", 128);

        // Start held high: one IDLE cycle, then the next dump begins
        runDump(0, HOOK_HELD, 400, doneAt, busyCycles);
        checkOutput("heldDoneAt", doneAt, 161);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1);
        #1;
        checkOutput("heldIdleGap", busy, 0);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1);
        #1;
        checkOutput("heldRestart", busy, 1);
        checkOutput("heldRestartAddr", rdAddr, 0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1);
        resetN = 1'b0;
        repeat (2) @(negedge clk);
        resetN = 1'b1;

        // Random register contents with random ready
        for (int k = 0; k < 32; k++) regs[k] = $urandom;
        buildExpected();
        runDump(2, HOOK_NONE, 3000, doneAt, busyCycles);
        checkOutput("randDoneSeen", doneAt > 0, 1);
        compareStream("rand", 128);
        idleCheck(2);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/reg_dump_unit.md
# reg_dump_unit

Debug-path block that reads the whole 32-entry register file through one combinational read port and streams its contents, byte by byte, into the UART transmitter. It sits between the register file's read port and the UART TX handshake. It asserts `o_busy` so the debug controller can halt the pipeline while the dump runs.

## Interface
- `NB_DATA`, 32, register width in bits; must be a multiple of 8.
- `NB_ADDR`, 5, register address width; the dump covers all 2**NB_ADDR registers.
- `NB_BYTE`, 8, width of the TX byte.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `i_reset`  in  1  reset, asynchronous, active-low.
- `i_start`  in  1  dump request; sampled only in IDLE.
- `o_rd_addr`  out  NB_ADDR  address driven to the register file read port.
- `i_rd_data`  in  NB_DATA  combinational read data returned for `o_rd_addr`.
- `o_tx_data`  out  NB_BYTE  byte offered to the UART TX.
- `o_tx_valid`  out  1  `o_tx_data` is valid.
- `i_tx_ready`  in  1  UART TX accepts a byte this cycle.
- `o_busy`  out  1  high from LOAD of register 0 through DONE.
- `o_done`  out  1  one-cycle pulse after the last byte is accepted.

## Operation
- FSM states: IDLE, LOAD, SEND, DONE.
- Internal state:
  - `reg_idx` (NB_ADDR bits) drives `o_rd_addr` directly.
  - `byte_idx` (clog2(NB_DATA/8) bits).
  - `word_q` (NB_DATA bits) holds a snapshot of the register being sent.
- IDLE:
  - `reg_idx`=0 and `byte_idx`=0.
  - On `i_start`=1, go to LOAD.
- LOAD (one cycle):
  - `word_q` <= `i_rd_data`.
  - `byte_idx` <= 0.
  - Go to SEND.
- SEND:
  - `o_tx_valid`=1.
  - `o_tx_data` = byte `byte_idx` of `word_q`, MSB first: byte 0 = `word_q[NB_DATA-1 -: 8]`.
  - A transfer occurs on a rising edge where `o_tx_valid` and `i_tx_ready` are both 1.
  - On a transfer that is not the last byte: `byte_idx`++.
  - On a transfer of the last byte (`byte_idx` = NB_DATA/8-1):
    - If `reg_idx` = 2**NB_ADDR-1, go to DONE.
    - Otherwise `reg_idx`++ and go to LOAD.
- DONE (one cycle):
  - `o_done`=1.
  - `reg_idx` <= 0.
  - Go to IDLE.
- `o_busy`=1 in LOAD, SEND and DONE; 0 in IDLE.
- Stream order: register 0 MSB byte first, through register 31 LSB byte last. Total 4·32 = 128 bytes at default parameters.
- Register 0 is sent as read; it is not forced to zero here.
- The snapshot is per register, taken at the LOAD edge. Register-file writes land on the falling edge, so a write on the falling edge preceding LOAD is captured. Writes during SEND are not reflected until that register's next LOAD.

## Timing
- Reset values: state IDLE, `o_rd_addr`=0, `o_tx_data`=0, `o_tx_valid`=0, `o_busy`=0, `o_done`=0; `word_q`=0, `byte_idx`=0.
- Start latency:
  - `i_start` sampled high at edge N puts the block in LOAD during cycle N+1.
  - `o_tx_valid` first rises in cycle N+2.
- Per register with `i_tx_ready` held at 1: 1 LOAD cycle + 4 SEND cycles = 5 cycles.
- Full dump with `i_tx_ready` held at 1: 160 cycles, then 1 DONE cycle. `o_done` is high in cycle N+161.
- Backpressure:
  - While `o_tx_valid`=1 and `i_tx_ready`=0, `o_tx_data`, `o_rd_addr` and the state hold stable.
  - `o_tx_valid` does not deassert until the transfer occurs.
- `o_tx_valid` is 0 in LOAD, so there is a one-cycle bubble between registers.
- `i_start` in any state other than IDLE is ignored; no queuing.
- `i_start` held high continuously: a new dump begins in the cycle right after DONE returns to IDLE (IDLE lasts one cycle).
- `i_tx_ready` is a don't-care outside SEND.
- Reset mid-dump:
  - Asynchronous return to IDLE with all outputs at reset values in the same cycle.
  - No `o_done` pulse.
  - The next `i_start` restarts from register 0.
- Wrap-around: `reg_idx` never increments past 2**NB_ADDR-1. The last-register check uses equality, not overflow.

## Test plan
- Reset and idle: hold `i_reset`=0, then release. Check all outputs are 0. Then wait 20 cycles with `i_start`=0: `o_busy` stays 0 and `o_tx_valid` stays 0.
- Full dump, no backpressure:
  - Preload register k = 32'hA0B0C000 + k and hold `i_tx_ready`=1.
  - Pulse `i_start` at edge N.
  - Expect 128 bytes in order A0,B0,C0,00,A0,B0,C0,01,…,A0,B0,C0,1F.
  - Expect `o_done` high in cycle N+161 only.
  - Expect `o_busy` high for cycles N+1..N+161.
- Backpressure:
  - Drive `i_tx_ready` with a pattern of 1 high cycle then 3 low cycles.
  - Check `o_tx_data` and `o_rd_addr` stay stable through the low cycles.
  - Check the byte stream is identical to the previous test, with no duplicated or dropped bytes.
- Snapshot semantics:
  - During SEND of register 5 (first byte accepted), write register 5 = 32'hDEADBEEF.
  - The remaining bytes still come from the old value.
  - A second dump shows DE,AD,BE,EF for register 5.
- Start ignored while busy: pulse `i_start` in SEND of register 3. The stream is unchanged, `o_done` pulses exactly once, and the block returns to IDLE.
- Reset mid-dump:
  - Assert `i_reset` during SEND of register 10, byte 2.
  - `o_tx_valid`, `o_busy` and `o_rd_addr` drop to 0 immediately, and no `o_done` pulse occurs.
  - After release, a new `i_start` produces a full stream beginning with register 0 MSB.
